// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

  // Smallest usable bit period in clk cycles; smaller divisors are clamped to this.
  localparam int UART_MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra bit
// so that full and empty stay distinct when the index bits are equal.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push while full or a pop while empty is ignored entirely.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards all queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered bytes serialised as 8N1 frames on txd.
// Write handshake: a byte is taken on a rising clk edge when wr_valid and
// wr_ready are both high; wr_ready depends only on the registered FIFO state,
// and a write with wr_ready low is dropped with no effect.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  input  logic                          tx_en,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic                          txd,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output uart_tx_state_e                tx_state
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0]       LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(UART_MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  uart_tx_state_e          state;
  uart_tx_state_e          state_d;
  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [DIV_WIDTH-1:0]    bit_period;
  logic [DIV_WIDTH-1:0]    eff_div;
  logic [BCW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_shift;
  logic [DATA_WIDTH-1:0]   fifo_data;
  logic                    frame_start;
  logic                    bit_end;
  logic                    can_start;
  logic                    txd_d;
  logic                    txd_q;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (frame_start),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr_ready    = ~fifo_full;
  assign eff_div     = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  assign bit_end     = (div_cnt == bit_period - DIV_ONE);
  assign can_start   = tx_en & ~fifo_empty;
  assign shreg_shift = shreg >> 1;
  assign busy        = (state != IDLE);
  assign txd         = txd_q;
  assign tx_state    = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; a frame starts (and pops the FIFO) from IDLE or at the end of STOP.
  always_comb begin
    state_d     = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (can_start) begin
          state_d     = START;
          frame_start = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (can_start) begin
            state_d     = START;
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the txd level that the next state will drive.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = (state == DATA && bit_end) ? shreg_shift[0] : shreg[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Registered serial output; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) txd_q <= 1'b1;
    else     txd_q <= txd_d;
  end

  // Bit timing and shift register; the divisor is sampled only at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_period <= MIN_DIV;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else if (frame_start) begin
      div_cnt    <= '0;
      bit_period <= eff_div;
      bit_cnt    <= '0;
      shreg      <= fifo_data;
    end else if (state != IDLE) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (state == DATA) begin
          bit_cnt <= bit_cnt + BCW'(1);
          shreg   <= shreg_shift;
        end
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level waveform checks against bit images
// built from each byte, a capacity-limited byte queue as reference, and
// hand sequences for reset, overflow, back-to-back and mid-frame changes.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        txd;
  logic        busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_level;
  uart_tx_state_e tx_state;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  uart_tx_engine dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .txd        (txd),
    .busy       (busy),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .tx_state   (tx_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one write per call, presented just after a rising edge.
  task automatic write_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Receive one frame sampled on falling edges; sample 0 is the first start-bit cycle.
  task automatic recv_frame(input logic [7:0] d, input int b, input bit contiguous,
                            output bit empty_at_start);
    logic [9:0] bits;
    logic [7:0] rx;
    int bad;
    int nbits;
    bit got;
    bits  = {1'b1, d, 1'b0};
    nbits = UART_FRAME_BITS * b;
    empty_at_start = 1'b0;
    if (contiguous) begin
      @(negedge clk);
      got = 1'b1;
    end else begin
      wait_start(got);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_start: got no start bit expected byte %0h", d);
      return;
    end
    empty_at_start = fifo_empty;
    bad = 0;
    rx  = '0;
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) @(negedge clk);
      if (txd !== bits[k / b] || busy !== 1'b1) bad++;
      if (k >= b && k < 9 * b && (k % b) == b / 2) rx[k / b - 1] = txd;
    end
    check($sformatf("frame_wave_%02h_b%0d", d, b), bad, 0);
    check($sformatf("frame_byte_b%0d", b), rx, d);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          exp_b;
  } vec_t;

  vec_t vecs[6];
  bit   e;
  bit   got;
  int   cnt;
  int   b;
  int   n;
  logic [7:0] d;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    tx_en    = 1'b0;
    baud_div = 16'd4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_state", 32'(tx_state), 32'(IDLE));

    // Single frames across divisors, including the clamp of 0 and 1
    vecs[0] = '{8'h55, 16'd4, 4};
    vecs[1] = '{8'h0F, 16'd0, 2};
    vecs[2] = '{8'h0F, 16'd1, 2};
    vecs[3] = '{8'hC3, 16'd5, 5};
    vecs[4] = '{8'h00, 16'd2, 2};
    vecs[5] = '{8'hFF, 16'd3, 3};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      baud_div = vecs[i].div;
      tx_en    = 1'b1;
      write_byte(vecs[i].data);
      check("push_not_empty", fifo_empty, 0);
      recv_frame(vecs[i].data, vecs[i].exp_b, 1'b0, e);
      @(negedge clk);
      check("busy_falls_after_frame", busy, 0);
      tx_en = 1'b0;
    end

    // Reset during data bit 3
    baud_div = 16'd4;
    write_byte(8'hA5);
    write_byte(8'h3C);
    tx_en = 1'b1;
    wait_start(got);
    check("rst_mid_started", got, 1);
    repeat (17) @(negedge clk);
    check("rst_mid_pre_txd", txd, 0);
    check("rst_mid_pre_level", fifo_level, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_empty", fifo_empty, 1);
    check("rst_mid_state", 32'(tx_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) cnt++;
    end
    check("rst_mid_stays_idle", cnt, 0);
    tx_en = 1'b0;

    // Back-to-back frames with no idle gap
    @(posedge clk);
    #1;
    baud_div = 16'd3;
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    tx_en = 1'b1;
    recv_frame(8'h01, 3, 1'b0, e);
    check("b2b_empty_at_01", e, 0);
    recv_frame(8'h80, 3, 1'b1, e);
    check("b2b_empty_at_80", e, 0);
    recv_frame(8'hFF, 3, 1'b1, e);
    check("b2b_empty_at_ff", e, 1);
    @(negedge clk);
    check("b2b_idle_after", busy, 0);
    tx_en = 1'b0;

    // Overflow: 17 writes into a 16-entry FIFO
    baud_div = 16'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("ovf_full", fifo_full, 1);
    check("ovf_wr_ready", wr_ready, 0);
    check("ovf_level16", fifo_level, 16);
    write_byte(8'h10);
    check("ovf_level_after_drop", fifo_level, 16);
    check("ovf_still_full", fifo_full, 1);
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) recv_frame(8'(i), 2, (i != 0), e);
    @(negedge clk);
    check("ovf_drained_busy", busy, 0);
    check("ovf_drained_empty", fifo_empty, 1);
    tx_en = 1'b0;

    // tx_en drop and divisor change during DATA
    @(posedge clk);
    #1;
    baud_div = 16'd5;
    write_byte(8'hC3);
    write_byte(8'h5A);
    tx_en = 1'b1;
    fork
      recv_frame(8'hC3, 5, 1'b0, e);
      begin
        repeat (12) @(posedge clk);
        #1;
        tx_en    = 1'b0;
        baud_div = 16'd8;
      end
    join
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) cnt++;
    end
    check("chg_held_while_disabled", cnt, 0);
    check("chg_level_held", fifo_level, 1);
    tx_en = 1'b1;
    recv_frame(8'h5A, 8, 1'b0, e);
    @(negedge clk);
    check("chg_idle_after", busy, 0);
    tx_en = 1'b0;

    // Randomized bursts against a capacity-limited byte queue
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      #1;
      baud_div = 16'($urandom_range(0, 6));
      b = (baud_div < UART_MIN_DIV) ? UART_MIN_DIV : int'(baud_div);
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        write_byte(d);
        if (exp_q.size() < 16) exp_q.push_back(d);
      end
      check("rnd_level", fifo_level, exp_q.size());
      check("rnd_full", fifo_full, (exp_q.size() == 16));
      tx_en = 1'b1;
      cnt = 0;
      while (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        recv_frame(d, b, (cnt != 0), e);
        cnt++;
      end
      @(negedge clk);
      check("rnd_idle_after", busy, 0);
      check("rnd_empty_after", fifo_empty, 1);
      tx_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit datapath behind the UART register block: accepts bytes written to the data register, buffers them in a FIFO, and serialises them onto `txd` as 8N1 frames (start, 8 data bits LSB first, stop) at a programmable bit period. FIFO and shifter status outputs feed the flag register. One instance per UART channel.

## Interface
- `DATA_WIDTH`, 8: bits per frame payload.
- `FIFO_DEPTH`, 16: transmit FIFO entries; power of two, minimum 2.
- `DIV_WIDTH`, 16: width of the bit-period divisor.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_valid`  in  1  byte offered for transmission (asserted on a data-register write).
- `wr_data`  in  DATA_WIDTH  byte to transmit.
- `wr_ready`  out  1  FIFO can accept; equals `!fifo_full`.
- `tx_en`  in  1  transmitter enable.
- `baud_div`  in  DIV_WIDTH  clk cycles per bit; values 0 and 1 are treated as 2.
- `txd`  out  1  serial output, idle high.
- `busy`  out  1  a frame is in progress.
- `fifo_empty`  out  1  FIFO holds no bytes.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH bytes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

## Operation
- Push on a rising edge with `wr_valid & wr_ready`. A write while full is dropped, with no state change.
- Pop happens when the FSM leaves IDLE or STOP to start a new frame. The popped byte loads the shift register.
- `fifo_level`:
  - push only: +1.
  - pop only: −1.
  - push and pop on the same edge: unchanged.
- `wr_ready` is based on the registered full flag. A same-edge pop does not open space for a push while full.
- FSM states are IDLE, START, DATA, STOP.
- IDLE → START when `tx_en & !fifo_empty`. This pops the FIFO, latches the effective `baud_div`, and clears the bit counter.
- START → DATA after one bit period.
- DATA → STOP after 8 bit periods. Bits go out LSB first, and the register shifts right at each bit boundary.
- STOP → START (back-to-back, no idle gap) if `tx_en & !fifo_empty` at the end of the stop bit. Otherwise STOP → IDLE.
- `txd` is a registered output with these values:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: the current shift-register LSB.
- Deasserting `tx_en` never truncates a frame. The current frame finishes and no new frame starts.
- `baud_div` changes take effect only at the next frame start.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - `txd` = 1, `busy` = 0, `fifo_empty` = 1, `fifo_full` = 0, `fifo_level` = 0, `wr_ready` = 1.
  - FSM in IDLE, FIFO pointers at 0.
- Reset asserted mid-frame forces `txd` high immediately (asynchronously) and discards all queued bytes.
- Push at edge N: `fifo_empty` falls after edge N.
- With the FSM idle and `tx_en`=1, the pop happens at edge N+1. `txd` goes low and `busy` rises after edge N+1.
- Each bit lasts exactly B = max(baud_div, 2) cycles. A frame lasts 10·B cycles.
- Back-to-back frames have no gap: the next start bit begins on the edge that ends the stop bit.
- Pointer wrap-around at FIFO_DEPTH is seamless. Full and empty are distinguished by the extra level bit.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_tx_state_e` enum (IDLE, START, DATA, STOP);
  - `UART_FRAME_BITS` = 10;
  - `UART_MIN_DIV` = 2.
- Sub-module `uart_sync_fifo` is a parameterised single-clock FIFO with push/pop/full/empty/level. The top level holds the divisor counter, bit counter, shift register and FSM.

## Test plan
- Reset mid-frame:
  - Stimulus: `baud_div`=4, write 0xA5, assert `rst` during bit 3.
  - Required: `txd`=1 immediately; level 0; FSM back in IDLE.
- Single byte:
  - Stimulus: `baud_div`=4, `tx_en`=1, write 0x55.
  - Required: `txd` is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; `busy` high for exactly 40 cycles.
- Back-to-back:
  - Stimulus: write 0x01, 0x80, 0xFF with `baud_div`=3.
  - Required: three contiguous 30-cycle frames, no idle gap; `fifo_empty` rises at the pop of 0xFF.
- Overflow:
  - Stimulus: `tx_en`=0, write 17 bytes 0x00–0x10.
  - Required: `fifo_full`=1 and `wr_ready`=0 after 16 writes; 0x10 dropped; level stays 16.
  - Follow-up: enable `tx_en`; exactly 0x00–0x0F are transmitted in order.
- Enable and divisor change mid-frame:
  - Stimulus: start 0xC3 at `baud_div`=5, then set `tx_en`=0 and `baud_div`=8 during DATA, with a second byte queued.
  - Required: 0xC3 completes at 5 cycles/bit; the second byte is held until `tx_en` returns, then sent at 8 cycles/bit.
- Divisor clamp:
  - Stimulus: `baud_div`=0, send 0x0F.
  - Required: 2 cycles per bit, 20-cycle frame.
